imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Sequential instruction encoder and loader for the LEGv8 single-cycle core. It is the writer side of the control decoder.
- Accepts symbolic instructions (class, registers, immediate) over a valid/ready stream and encodes each one into a 32-bit LEGv8 machine word.
- Writes the words to consecutive instruction-memory locations through a synchronous write port.
- Used by benches and boot logic to load programs that the core's decoder later consumes.

Parameters:
- ADDR_W, 6, width of word address into instruction memory.
- DEPTH, 64, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin or restart a load at word 0.
- finish  in  1  one-cycle pulse: end the load.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  loader accepts a beat this cycle.
- in_op  in  3  class: 0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal.
- in_rt  in  5  Rt/Rd field.
- in_rn  in  5  Rn field.
- in_rm  in  5  Rm field (R-format only).
- in_imm  in  19  DT address (uses [8:0]) or CBZ offset (uses [18:0]).
- wr_en  out  1  imem write strobe.
- wr_addr  out  ADDR_W  imem word address.
- wr_data  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written in the current load.
- busy  out  1  in LOAD state.
- full  out  1  DEPTH words written.
- done  out  1  one-cycle pulse on leaving LOAD via finish.
- err  out  1  sticky: a beat was dropped.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including wr_en, wr_addr, wr_data, word_count, err and done.
- States:
  - IDLE –start→ LOAD.
  - LOAD –finish→ DONE.
  - LOAD –word_count reaches DEPTH→ FULL.
  - FULL –finish→ DONE.
  - DONE → IDLE next cycle; done=1 for that one cycle.
  - start in any state → LOAD, clearing word_count, next address and err.
- in_ready = (state==LOAD) && !start. A beat is accepted when in_valid && in_ready.
- Latency: an accepted legal beat produces wr_en=1 in the following cycle.
  - wr_addr = address at acceptance; wr_data = encoded word; word_count increments in that same cycle.
  - wr_en is a single-cycle pulse per beat.
  - Back-to-back beats give one write per cycle.
- Encoding:
  - LDUR: {11'b111_1100_0010, imm[8:0], 2'b00, rn, rt}.
  - STUR: {11'b111_1100_0000, imm[8:0], 2'b00, rn, rt}.
  - CBZ: {8'b1011_0100, imm[18:0], rt}.
  - ADD/SUB/AND/ORR: opcode 11'b100_0101_1000 / 11'b110_0101_1000 / 11'b100_0101_0000 / 11'b101_0101_0000, then rm, shamt=6'b0, rn, rt.
- Illegal op 7: the beat is accepted (handshake completes). No write, word_count unchanged, err set.
- Full: after the DEPTH-th write, state is FULL, full=1 and in_ready=0. Address never wraps.
- finish with an accepted beat in the same cycle: the beat is written, then DONE.
- finish in IDLE or DONE: ignored.
- start and finish together: start wins.
- Reset mid-load: any pending write is discarded and the write port is not strobed.
- wr_data holds its last value when wr_en=0.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: for LDUR/STUR, in_imm[18:9] must equal a sign-extension of in_imm[8]. Otherwise the beat is accepted but dropped and err is set, same as an illegal op.
- Undefined: in_imm[18:9] is ignored for LDUR/STUR (silent truncation) and no check logic exists.

Test Plan:
- start; beat LDUR rt=1 rn=2 imm=8 → next cycle wr_en=1, wr_addr=0, wr_data=0xF8408041, word_count=1.
- Back-to-back beats ADD rt=3 rn=1 rm=2, then CBZ rt=0 imm=0x7FFFE → writes 0x8B020023 at addr 0, then 0xB4FFFFC0 at addr 1 on consecutive cycles.
- STUR rt=5 rn=6 imm=0x7FFFF → wr_data=0xF81FF0C5. Same beat with imm=0x001FF: with the macro, dropped and err=1; without, 0xF81FF0C5.
- DEPTH=4, hold in_valid with 6 legal beats → exactly 4 writes at addrs 0..3, full=1, in_ready=0; finish → done pulses once, then IDLE.
- Beat op=7 between two legal beats → 2 writes at addrs 0,1, err=1; a later start clears err and word_count.
- Assert reset the cycle after an accepted beat → no wr_en, all outputs 0; start after release loads at addr 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Instruction beat stream and instruction-memory write port for imem_loader.
// The slave modport is the loader side; master is the producer/memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rt;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [18:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_op, in_rt, in_rn, in_rm, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_rt, in_rn, in_rm, in_imm,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// LEGv8 instruction encoder/loader: encodes symbolic beats and writes them to consecutive imem words.
// Optional macro IMM_RANGE_CHECK_EN drops LDUR/STUR beats whose imm[18:9] is not a sign-extension of imm[8].
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            finish,
    imem_loader_if.slave    bus,
    output logic [ADDR_W:0] word_count,
    output logic            busy,
    output logic            full,
    output logic            done,
    output logic            err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic [31:0]       r_wr_data;
    logic [ADDR_W:0]   r_word_count;
    logic              r_err;
    logic              w_ready;
    logic              w_accept;
    logic              w_legal;
    logic [31:0]       w_enc;

    assign w_accept = bus.in_valid && w_ready;

`ifdef IMM_RANGE_CHECK_EN
    logic w_imm_ok;
    // Only data-transfer formats truncate the immediate; CBZ uses all 19 bits.
    assign w_imm_ok = (bus.in_op > 3'd1) || (bus.in_imm[18:9] == {10{bus.in_imm[8]}});
    assign w_legal  = (bus.in_op != 3'd7) && w_imm_ok;
`else
    assign w_legal  = (bus.in_op != 3'd7);
`endif

    always_comb begin
        w_enc = '0;
        case (bus.in_op)
            3'd0: w_enc = {11'b111_1100_0010, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
            3'd1: w_enc = {11'b111_1100_0000, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
            3'd2: w_enc = {8'b1011_0100, bus.in_imm, bus.in_rt};
            3'd3: w_enc = {11'b100_0101_1000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rt};
            3'd4: w_enc = {11'b110_0101_1000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rt};
            3'd5: w_enc = {11'b100_0101_0000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rt};
            3'd6: w_enc = {11'b101_0101_0000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rt};
            default: w_enc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FULL is entered together with the DEPTH-th write so no further beat is taken.
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_LOAD: begin
                    if (finish)
                        w_next = S_DONE;
                    else if (w_accept && w_legal && (r_word_count == LAST_CNT))
                        w_next = S_FULL;
                end
                S_FULL: if (finish) w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready = (r_state == S_LOAD) && !start;
        busy    = (r_state == S_LOAD);
        done    = (r_state == S_DONE);
        full    = (r_word_count == FULL_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_next_addr  <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (start) begin
                r_word_count <= '0;
                r_next_addr  <= '0;
                r_err        <= 1'b0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_wr_en      <= 1'b1;
                    r_wr_addr    <= r_next_addr;
                    r_wr_data    <= w_enc;
                    r_next_addr  <= r_next_addr + ADDR_W'(1);
                    r_word_count <= r_word_count + (ADDR_W+1)'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign word_count   = r_word_count;
    assign err          = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads against a flag-level model.
module tb_imem_loader;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            finish = 1'b0;
    logic [ADDR_W:0] word_count;
    logic            busy, full, done, err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit          m_load;
    bit          m_full_st;
    bit          m_done;
    bit          m_err;
    int          m_count;
    logic [31:0] m_data;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .finish     (finish),
        .bus        (bus),
        .word_count (word_count),
        .busy       (busy),
        .full       (full),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_encode(input int unsigned op, input int unsigned rt,
                                               input int unsigned rn, input int unsigned rm,
                                               input int unsigned imm);
        int unsigned opc;
        case (op)
            0: return (32'h7C2 << 21) + ((imm % 512) << 12) + (rn << 5) + rt;
            1: return (32'h7C0 << 21) + ((imm % 512) << 12) + (rn << 5) + rt;
            2: return (32'hB4 << 24) + (imm << 5) + rt;
            default: begin
                opc = (op == 3) ? 32'h458 : (op == 4) ? 32'h658 : (op == 5) ? 32'h450 : 32'h550;
                return (opc << 21) + (rm << 16) + (rn << 5) + rt;
            end
        endcase
    endfunction

    function automatic bit ref_legal(input int unsigned op, input int unsigned imm);
        if (op == 7) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        if (op <= 1) begin
            int sx;
            sx = ((imm >> 8) & 1) ? 32'h3FF : 0;
            return ((imm >> 9) == sx);
        end
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_load = 0; m_full_st = 0; m_done = 0; m_err = 0; m_count = 0; m_data = '0;
    endtask

    task automatic step(input bit s, input bit f, input bit v, input logic [2:0] op,
                        input logic [4:0] rt, input logic [4:0] rn, input logic [4:0] rm,
                        input logic [18:0] imm);
        bit exp_ready, acc, legal, exp_wen, nd;
        int exp_addr;
        start = s; finish = f;
        bus.in_valid = v; bus.in_op = op; bus.in_rt = rt; bus.in_rn = rn;
        bus.in_rm = rm; bus.in_imm = imm;
        #1;
        exp_ready = m_load && !s;
        chk("in_ready", bus.in_ready, exp_ready);
        acc   = v && exp_ready;
        legal = ref_legal(op, imm);
        exp_wen  = acc && legal;
        exp_addr = m_count;
        @(posedge clk);
        #1;
        if (exp_wen) m_data = ref_encode(op, rt, rn, rm, imm);
        if (s) begin
            m_count = 0; m_err = 0; m_load = 1; m_full_st = 0; m_done = 0;
        end else begin
            if (exp_wen) m_count++;
            if (acc && !legal) m_err = 1;
            nd = f && (m_load || m_full_st);
            if (nd) begin
                m_load = 0; m_full_st = 0;
            end else if (m_load && m_count == DEPTH) begin
                m_load = 0; m_full_st = 1;
            end
            m_done = nd;
        end
        chk("wr_en", bus.wr_en, exp_wen);
        if (exp_wen) chk("wr_addr", bus.wr_addr, exp_addr);
        chk("wr_data", bus.wr_data, m_data);
        chk("word_count", word_count, m_count);
        chk("err", err, m_err);
        chk("busy", busy, m_load);
        chk("full", full, m_count == DEPTH);
        chk("done", done, m_done);
        start = 0; finish = 0; bus.in_valid = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_count"}, word_count, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_op = 0; bus.in_rt = 0; bus.in_rn = 0;
        bus.in_rm = 0; bus.in_imm = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;

        // Single LDUR
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        step(0, 0, 1, 3'd0, 5'd1, 5'd2, 5'd0, 19'd8);
        chk("ldur_data", bus.wr_data, 32'hF8408041);
        chk("ldur_addr", bus.wr_addr, 0);

        // Back-to-back ADD, CBZ
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        step(0, 0, 1, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
        chk("add_data", bus.wr_data, 32'h8B020023);
        step(0, 0, 1, 3'd2, 5'd0, 5'd0, 5'd0, 19'h7FFFE);
        chk("cbz_data", bus.wr_data, 32'hB4FFFFC0);
        chk("cbz_addr", bus.wr_addr, 1);

        // STUR immediate truncation / range check
        step(0, 0, 1, 3'd1, 5'd5, 5'd6, 5'd0, 19'h7FFFF);
        chk("stur_data", bus.wr_data, 32'hF81FF0C5);
        step(0, 0, 1, 3'd1, 5'd5, 5'd6, 5'd0, 19'h001FF);
`ifdef IMM_RANGE_CHECK_EN
        chk("stur_range_err", err, 1);
        chk("stur_range_wen", bus.wr_en, 0);
`else
        chk("stur_trunc_data", bus.wr_data, 32'hF81FF0C5);
        chk("stur_trunc_err", err, 0);
`endif

        // Fill to DEPTH with valid held, then finish
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 3'd4, 5'(i), 5'd7, 5'd9, 19'd0);
        chk("fill_full", full, 1);
        chk("fill_ready", bus.in_ready, 0);
        chk("fill_count", word_count, DEPTH);
        step(0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        chk("fill_done", done, 1);
        idle();
        chk("fill_done_clr", done, 0);
        step(0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        chk("finish_idle_ignored", done, 0);

        // Illegal op between legal beats
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        step(0, 0, 1, 3'd5, 5'd1, 5'd1, 5'd1, 19'd0);
        step(0, 0, 1, 3'd7, 5'd2, 5'd2, 5'd2, 19'd0);
        step(0, 0, 1, 3'd6, 5'd3, 5'd3, 5'd3, 19'd0);
        chk("illegal_addr", bus.wr_addr, 1);
        chk("illegal_err", err, 1);
        step(1, 1, 1, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        chk("restart_err", err, 0);
        chk("restart_count", word_count, 0);
        chk("restart_busy", busy, 1);

        // Finish together with an accepted beat
        step(0, 1, 1, 3'd3, 5'd4, 5'd5, 5'd6, 19'd0);
        chk("fin_beat_wen", bus.wr_en, 1);
        chk("fin_beat_done", done, 1);
        idle();

        // Reset in the cycle after an accepted beat
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        bus.in_valid = 1; bus.in_op = 3'd0; bus.in_rt = 5'd9; bus.in_rn = 5'd8; bus.in_imm = 19'd3;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.in_valid = 0;
        #1;
        model_reset();
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        chk("midrst_wen2", bus.wr_en, 0);
        reset = 1'b1;
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        step(0, 0, 1, 3'd1, 5'd1, 5'd1, 5'd0, 19'd1);
        chk("postrst_addr", bus.wr_addr, 0);

        // Randomized loads
        for (int l = 0; l < 30; l++) begin
            step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
            for (int k = 0; k < 10; k++) begin
                logic [2:0] op;
                op = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
                step(($urandom_range(0, 24) == 0), ($urandom_range(0, 11) == 0),
                     ($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom),
                     5'($urandom), 19'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
